// File: rtl/gshare_branch_unit_pkg.sv
// gshare_branch_unit_pkg: shared branch opcodes, 2-bit counter encodings and counter update helper
package gshare_branch_unit_pkg;

    localparam logic [7:0] EXE_BEQ_OP    = 8'h10;
    localparam logic [7:0] EXE_BNE_OP    = 8'h11;
    localparam logic [7:0] EXE_BLEZ_OP   = 8'h12;
    localparam logic [7:0] EXE_BGTZ_OP   = 8'h13;
    localparam logic [7:0] EXE_BLTZ_OP   = 8'h14;
    localparam logic [7:0] EXE_BGEZ_OP   = 8'h15;
    localparam logic [7:0] EXE_BLTZAL_OP = 8'h16;
    localparam logic [7:0] EXE_BGEZAL_OP = 8'h17;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic taken);
        return taken ? ((c == ST) ? ST : c + 2'd1) : ((c == SNT) ? SNT : c - 2'd1);
    endfunction

endpackage

// File: rtl/gshare_branch_unit_cond.sv
// branch_cond_eval: decodes a branch opcode and evaluates its condition on the forwarded operands
module branch_cond_eval
    import gshare_branch_unit_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [7:0]        ctrl_i,
    input  logic [DATA_W-1:0] srca_i,
    input  logic [DATA_W-1:0] srcb_i,
    output logic              is_branch_o,
    output logic              take_o
);

    logic neg, zero;

    assign neg  = srca_i[DATA_W-1];
    assign zero = ~|srca_i;

    always_comb begin
        is_branch_o = 1'b1;
        take_o      = 1'b0;
        case (ctrl_i)
            EXE_BEQ_OP:                  take_o = srca_i == srcb_i;
            EXE_BNE_OP:                  take_o = srca_i != srcb_i;
            EXE_BGTZ_OP:                 take_o = !neg && !zero;
            EXE_BLEZ_OP:                 take_o = neg || zero;
            EXE_BLTZ_OP, EXE_BLTZAL_OP:  take_o = neg;
            EXE_BGEZ_OP, EXE_BGEZAL_OP:  take_o = !neg;
            default:                     is_branch_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/gshare_branch_unit.sv
// gshare_branch_unit: gshare direction predictor with speculative GHR, branch resolve and statistics
module gshare_branch_unit
    import gshare_branch_unit_pkg::*;
#(
    parameter int PHT_IDX_W = 10,
    parameter int GHR_W     = 8,
    parameter int DATA_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall_i,
    input  logic                 pred_valid_i,
    input  logic [DATA_W-1:0]    pred_pc_i,
    output logic                 pred_take_o,
    output logic [GHR_W-1:0]     pred_ghr_o,
    output logic [PHT_IDX_W-1:0] pred_idx_o,
    input  logic                 res_valid_i,
    input  logic [7:0]           res_ctrl_i,
    input  logic [DATA_W-1:0]    res_srca_i,
    input  logic [DATA_W-1:0]    res_srcb_i,
    input  logic                 res_pred_take_i,
    input  logic [GHR_W-1:0]     res_ghr_i,
    input  logic [PHT_IDX_W-1:0] res_idx_i,
    input  logic [DATA_W-1:0]    res_target_i,
    input  logic [DATA_W-1:0]    res_pc_plus8_i,
    output logic                 branch_take_o,
    output logic                 mispredict_o,
    output logic [DATA_W-1:0]    redirect_pc_o,
    output logic [31:0]          stat_branches_o,
    output logic [31:0]          stat_mispred_o
);

    localparam int PHT_DEPTH = 1 << PHT_IDX_W;

    logic [1:0]       pht_q [PHT_DEPTH];
    logic [GHR_W-1:0] ghr_q, ghr_d;
    logic [31:0]      stat_br_q, stat_br_d, stat_mis_q, stat_mis_d;
    logic             is_branch, res_ok, unused_pc;

    branch_cond_eval #(.DATA_W(DATA_W)) u_cond (
        .ctrl_i      (res_ctrl_i),
        .srca_i      (res_srca_i),
        .srcb_i      (res_srcb_i),
        .is_branch_o (is_branch),
        .take_o      (branch_take_o)
    );

    assign unused_pc       = ^{pred_pc_i[DATA_W-1:PHT_IDX_W+2], pred_pc_i[1:0]};
    assign res_ok          = res_valid_i & is_branch;
    assign pred_idx_o      = pred_pc_i[PHT_IDX_W+1:2] ^ PHT_IDX_W'(ghr_q);
    assign pred_take_o     = pred_valid_i & pht_q[pred_idx_o][1];
    assign pred_ghr_o      = ghr_q;
    assign mispredict_o    = res_ok & (branch_take_o ^ res_pred_take_i);
    assign redirect_pc_o   = branch_take_o ? res_target_i : res_pc_plus8_i;
    assign stat_branches_o = stat_br_q;
    assign stat_mispred_o  = stat_mis_q;

    // Truncating {history, bit} to GHR_W drops the oldest bit, which also covers GHR_W=1
    always_comb begin
        ghr_d      = mispredict_o ? GHR_W'({res_ghr_i, branch_take_o})
                   : (pred_valid_i && !stall_i) ? GHR_W'({ghr_q, pred_take_o}) : ghr_q;
        stat_br_d  = stat_br_q + 32'(res_ok && stat_br_q != '1);
        stat_mis_d = stat_mis_q + 32'(mispredict_o && stat_mis_q != '1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PHT_DEPTH; i++) pht_q[i] <= WNT;
            ghr_q      <= '0;
            stat_br_q  <= '0;
            stat_mis_q <= '0;
        end else begin
            if (res_ok) pht_q[res_idx_i] <= ctr_next(pht_q[res_idx_i], branch_take_o);
            ghr_q      <= ghr_d;
            stat_br_q  <= stat_br_d;
            stat_mis_q <= stat_mis_d;
        end
    end

endmodule

// File: tb/tb_gshare_branch_unit.sv
// tb_gshare_branch_unit: directed literal checks plus randomized run against a behavioural gshare model
module tb_gshare_branch_unit;
    import gshare_branch_unit_pkg::*;

    logic        clk = 1'b0, rst, stall_i, pred_valid_i, res_valid_i, res_pred_take_i;
    logic [31:0] pred_pc_i, res_srca_i, res_srcb_i, res_target_i, res_pc_plus8_i;
    logic [7:0]  res_ctrl_i, res_ghr_i, pred_ghr_o;
    logic [9:0]  res_idx_i, pred_idx_o;
    logic        pred_take_o, branch_take_o, mispredict_o;
    logic [31:0] redirect_pc_o, stat_branches_o, stat_mispred_o;

    int          m_pht [1024];
    logic [7:0]  m_ghr;
    logic [31:0] m_br, m_mis;
    bit          m_known = 0;
    int          checks = 0, errors = 0;

    gshare_branch_unit #(.PHT_IDX_W(10), .GHR_W(8), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .pred_valid_i(pred_valid_i), .pred_pc_i(pred_pc_i),
        .pred_take_o(pred_take_o), .pred_ghr_o(pred_ghr_o), .pred_idx_o(pred_idx_o),
        .res_valid_i(res_valid_i), .res_ctrl_i(res_ctrl_i), .res_srca_i(res_srca_i), .res_srcb_i(res_srcb_i),
        .res_pred_take_i(res_pred_take_i), .res_ghr_i(res_ghr_i), .res_idx_i(res_idx_i),
        .res_target_i(res_target_i), .res_pc_plus8_i(res_pc_plus8_i),
        .branch_take_o(branch_take_o), .mispredict_o(mispredict_o), .redirect_pc_o(redirect_pc_o),
        .stat_branches_o(stat_branches_o), .stat_mispred_o(stat_mispred_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Returns {is_branch, taken} straight from the opcode definitions
    function automatic logic [1:0] ref_cond(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa;
        sa = signed'(a);
        case (op)
            EXE_BEQ_OP:                 return {1'b1, a == b};
            EXE_BNE_OP:                 return {1'b1, a != b};
            EXE_BGTZ_OP:                return {1'b1, sa > 0};
            EXE_BLEZ_OP:                return {1'b1, sa <= 0};
            EXE_BLTZ_OP, EXE_BLTZAL_OP: return {1'b1, sa < 0};
            EXE_BGEZ_OP, EXE_BGEZAL_OP: return {1'b1, sa >= 0};
            default:                    return 2'b00;
        endcase
    endfunction

    task automatic idle();
        rst = 0; stall_i = 0; pred_valid_i = 0; pred_pc_i = 0;
        res_valid_i = 0; res_ctrl_i = 0; res_srca_i = 0; res_srcb_i = 0; res_pred_take_i = 0;
        res_ghr_i = 0; res_idx_i = 0; res_target_i = 32'h1000; res_pc_plus8_i = 32'h2008;
    endtask

    // One clock: compare every output against the model at the falling edge, then advance the model
    task automatic step();
        logic [9:0]  e_idx;
        logic [1:0]  c;
        logic        e_take, v, e_mis;
        @(negedge clk);
        e_idx  = pred_pc_i[11:2] ^ {2'b00, m_ghr};
        e_take = pred_valid_i && m_pht[e_idx] >= 2;
        c      = ref_cond(res_ctrl_i, res_srca_i, res_srcb_i);
        v      = res_valid_i && c[1];
        e_mis  = v && (c[0] != res_pred_take_i);
        if (m_known) begin
            chk("pred_idx", pred_idx_o, e_idx);
            chk("pred_take", pred_take_o, e_take);
            chk("pred_ghr", pred_ghr_o, m_ghr);
            chk("branch_take", branch_take_o, c[0]);
            chk("mispredict", mispredict_o, e_mis);
            chk("redirect", redirect_pc_o, c[0] ? res_target_i : res_pc_plus8_i);
            chk("stat_br", stat_branches_o, m_br);
            chk("stat_mis", stat_mispred_o, m_mis);
        end
        if (rst) begin
            foreach (m_pht[i]) m_pht[i] = 1;
            m_ghr = 0; m_br = 0; m_mis = 0; m_known = 1;
        end else begin
            if (v) m_pht[res_idx_i] = c[0] ? ((m_pht[res_idx_i] == 3) ? 3 : m_pht[res_idx_i] + 1)
                                           : ((m_pht[res_idx_i] == 0) ? 0 : m_pht[res_idx_i] - 1);
            if (e_mis) m_ghr = {res_ghr_i[6:0], c[0]};
            else if (pred_valid_i && !stall_i) m_ghr = {m_ghr[6:0], e_take};
            if (v && m_br != 32'hFFFFFFFF) m_br = m_br + 1;
            if (e_mis && m_mis != 32'hFFFFFFFF) m_mis = m_mis + 1;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pick_op();
        case ($urandom % 6)
            0: return 32'h0;
            1: return 32'h5;
            2: return 32'hFFFFFFFF;
            3: return 32'h7FFFFFFF;
            4: return 32'h80000000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [7:0]  ops [8];
        logic [31:0] br_snap;
        bit          exp_up [4], exp_dn [4];
        ops = '{EXE_BEQ_OP, EXE_BNE_OP, EXE_BLEZ_OP, EXE_BGTZ_OP, EXE_BLTZ_OP, EXE_BGEZ_OP, EXE_BLTZAL_OP, EXE_BGEZAL_OP};
        exp_up = '{0, 1, 1, 1};
        exp_dn = '{1, 1, 0, 0};
        idle(); rst = 1;
        step(); step();
        rst = 0;
        // Post-reset predict
        pred_valid_i = 1; pred_pc_i = 32'h00400000; #1;
        chk("r026_take", pred_take_o, 0); chk("r026_idx", pred_idx_o, 0); chk("r026_ghr", pred_ghr_o, 0);
        step();
        // BEQ taken against a not-taken prediction
        idle(); res_valid_i = 1; res_ctrl_i = EXE_BEQ_OP; res_srca_i = 5; res_srcb_i = 5;
        res_idx_i = 10'h004; res_ghr_i = 8'h5A; #1;
        chk("r027_take", branch_take_o, 1); chk("r027_mis", mispredict_o, 1); chk("r027_redirect", redirect_pc_o, 32'h1000);
        step();
        idle(); pred_valid_i = 1; stall_i = 1; pred_pc_i = {20'b0, 10'h004 ^ 10'h0B5, 2'b00}; #1;
        chk("r027_ghr", pred_ghr_o, 8'hB5); chk("r027_pht_wt", pred_take_o, 1);
        step();
        // Saturation on idx 0x010, probing the same index each cycle (old value is visible)
        for (int k = 0; k < 4; k++) begin
            idle(); pred_valid_i = 1; stall_i = 1; pred_pc_i = {20'b0, 10'h010 ^ 10'h0B5, 2'b00};
            res_valid_i = 1; res_ctrl_i = EXE_BEQ_OP; res_srca_i = 1; res_srcb_i = 1; res_idx_i = 10'h010; res_pred_take_i = 1; #1;
            chk($sformatf("r028_up%0d", k), pred_take_o, exp_up[k]);
            step();
        end
        for (int k = 0; k < 4; k++) begin
            idle(); pred_valid_i = 1; stall_i = 1; pred_pc_i = {20'b0, 10'h010 ^ 10'h0B5, 2'b00};
            res_valid_i = 1; res_ctrl_i = EXE_BNE_OP; res_srca_i = 1; res_srcb_i = 1; res_idx_i = 10'h010; #1;
            chk($sformatf("r028_dn%0d", k), pred_take_o, exp_dn[k]);
            chk($sformatf("r028_nomis%0d", k), mispredict_o, 0);
            step();
        end
        idle(); pred_valid_i = 1; stall_i = 1; pred_pc_i = {20'b0, 10'h010 ^ 10'h0B5, 2'b00}; #1;
        chk("r028_hold", pred_take_o, 0);
        step();
        // Mispredict recovery beats a same-cycle speculative shift
        idle(); pred_valid_i = 1; res_valid_i = 1; res_ctrl_i = EXE_BLTZ_OP; res_srca_i = 32'hFFFFFFFF;
        res_ghr_i = 8'h0F; res_idx_i = 10'h030; #1;
        chk("r029_mis", mispredict_o, 1);
        step();
        idle(); #1;
        chk("r029_ghr", pred_ghr_o, 8'h1F);
        // Statistics saturation
        force dut.stat_mis_q = 32'hFFFFFFFE;
        #1;
        release dut.stat_mis_q;
        m_mis = 32'hFFFFFFFE;
        for (int k = 0; k < 2; k++) begin
            idle(); res_valid_i = 1; res_ctrl_i = EXE_BEQ_OP; res_srca_i = 3; res_srcb_i = 3; res_idx_i = 10'h020;
            res_ghr_i = 8'h1F;
            step();
        end
        idle(); #1;
        chk("r031_sat", stat_mispred_o, 32'hFFFFFFFF);
        br_snap = stat_branches_o;
        res_valid_i = 1; res_ctrl_i = 8'h00; res_srca_i = 3; res_srcb_i = 3; res_idx_i = 10'h020; #1;
        chk("r031_nop_take", branch_take_o, 0); chk("r031_nop_mis", mispredict_o, 0);
        step();
        idle(); #1;
        chk("r031_nop_br", stat_branches_o, br_snap); chk("r031_nop_ghr", pred_ghr_o, 8'h3F);
        // Randomized run
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom % 200) == 0;
            stall_i = ($urandom % 4) == 0;
            pred_valid_i = $urandom % 2;
            pred_pc_i = $urandom;
            res_valid_i = ($urandom % 4) != 0;
            res_ctrl_i = (($urandom % 8) == 0) ? 8'($urandom) : ops[$urandom % 8];
            res_srca_i = pick_op();
            res_srcb_i = pick_op();
            res_pred_take_i = $urandom % 2;
            res_ghr_i = 8'($urandom);
            res_idx_i = 10'($urandom % 16);
            res_target_i = $urandom;
            res_pc_plus8_i = $urandom;
            step();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gshare_branch_unit.md
GSHARE_BRANCH_UNIT -- requirements
Module: gshare_branch_unit

Interface
REQ-001 The block SHALL have parameter PHT_IDX_W, default 10, giving log2 of the pattern history table (PHT) depth.
REQ-002 The block SHALL have parameter GHR_W, default 8, giving the global history register width; legal range 1..PHT_IDX_W.
REQ-003 The block SHALL have parameter DATA_W, default 32, giving the operand and PC width.
REQ-004 The block SHALL have these ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- stall_i  in  1  freezes speculative GHR update.
- pred_valid_i  in  1  fetch slot holds a branch.
- pred_pc_i  in  DATA_W  fetch PC.
- pred_take_o  out  1  predicted direction.
- pred_ghr_o  out  GHR_W  GHR checkpoint, carried down the pipe.
- pred_idx_o  out  PHT_IDX_W  PHT index, carried down the pipe.
- res_valid_i  in  1  decode slot holds a branch to resolve.
- res_ctrl_i  in  8  branch opcode (EXE_*_OP encoding).
- res_srca_i, res_srcb_i  in  DATA_W  forwarded operands.
- res_pred_take_i  in  1  carried prediction.
- res_ghr_i  in  GHR_W  carried checkpoint.
- res_idx_i  in  PHT_IDX_W  carried index.
- res_target_i, res_pc_plus8_i  in  DATA_W  taken and fall-through PCs.
- branch_take_o  out  1  actual direction.
- mispredict_o  out  1  redirect required.
- redirect_pc_o  out  DATA_W  correct next PC.
- stat_branches_o, stat_mispred_o  out  32  statistics counters.

Function
REQ-005 pred_idx_o SHALL equal pred_pc_i[PHT_IDX_W+1:2] XOR zero-extended GHR, combinationally.
REQ-006 pred_take_o SHALL equal bit 1 of PHT[pred_idx_o], read combinationally from the current-cycle state; it SHALL be 0 when pred_valid_i=0.
REQ-007 pred_ghr_o SHALL present the GHR value before this cycle's update.
REQ-008 Conditions: BEQ a==b; BNE a!=b; BGTZ a>0 signed; BLEZ a<=0 signed; BLTZ and BLTZAL a<0; BGEZ and BGEZAL a>=0.
REQ-009 Any other res_ctrl_i SHALL give branch_take_o=0 and SHALL cause no update, no mispredict and no stat count.
REQ-010 A resolve is valid when res_valid_i=1 and res_ctrl_i is one of the eight branch codes.
REQ-011 mispredict_o SHALL equal valid resolve AND (branch_take_o != res_pred_take_i), combinationally in the same cycle.
REQ-012 redirect_pc_o SHALL be res_target_i when branch_take_o=1, else res_pc_plus8_i.
REQ-013 On a valid resolve, PHT[res_idx_i] SHALL update at the next edge as a 2-bit saturating counter: increment if taken, decrement if not, holding at 11 and at 00.
REQ-014 GHR speculative update: when pred_valid_i=1, stall_i=0 and there is no mispredict, GHR SHALL shift to {GHR[GHR_W-2:0], pred_take_o}; for GHR_W=1 it SHALL load pred_take_o.
REQ-015 On mispredict_o=1, GHR SHALL load {res_ghr_i[GHR_W-2:0], branch_take_o}.
REQ-016 Mispredict recovery SHALL override a same-cycle speculative update, including when stall_i=1.
REQ-017 When a predict and an update hit the same index in the same cycle, the prediction SHALL use the old counter value; there is no bypass.
REQ-018 stat_branches_o SHALL increment on each valid resolve, and stat_mispred_o on each mispredict.
REQ-019 Both statistics counters SHALL saturate at 0xFFFFFFFF.

Reset
REQ-020 When rst=1 at an edge, every PHT entry SHALL become 01 (weakly not-taken), GHR SHALL become 0 and both statistics counters SHALL become 0.
REQ-021 A resolve or predict coinciding with rst SHALL be discarded.
REQ-022 The combinational outputs SHALL reflect post-reset state from the next cycle onward.

Structure
REQ-023 The EXE_*_OP branch codes and the counter encodings (SNT=00, WNT=01, WT=10, ST=11) SHALL live in the shared defines header.
REQ-024 The condition evaluation (REQ-008 and REQ-009) SHALL be a combinational sub-module named branch_cond_eval.
REQ-025 The PHT SHALL be a register array, not a RAM macro.

Verification
REQ-026 Reset, then predict at pc=0x00400000 -> pred_take_o=0, pred_idx_o=0x000, pred_ghr_o=0x00.
REQ-027 Resolve BEQ with a=b=5, idx=0x004, pred=0 -> branch_take_o=1, mispredict_o=1, redirect_pc_o=res_target_i; next cycle PHT[0x004]=10 and GHR={res_ghr_i[6:0],1}.
REQ-028 Four consecutive taken resolves on idx 0x010 -> counter goes 01,10,11,11,11; four not-taken resolves then drop it to 00 and hold.
REQ-029 Same cycle: predict with pred_valid_i=1 plus a mispredicting BLTZ (a=0xFFFFFFFF, pred=0, res_ghr_i=0x0F) -> GHR=0x1F and the speculative shift is dropped.
REQ-030 Same-index predict and update in one cycle (counter 01, taken update) -> pred_take_o=0 that cycle and 1 the next.
REQ-031 Force stat_mispred_o=0xFFFFFFFE, apply two mispredicts -> it holds at 0xFFFFFFFF; res_ctrl_i=0x00 with res_valid_i=1 leaves all state unchanged.
